// File: rtl/alu_iter_pkg.sv
// Shared operation codes and FSM encodings for the iterative ALU and its controller.
// Pure declarations: no latency, no backpressure.
package alu_iter_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_MUL = 4'b0011,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Shift-add multiplier datapath: one multiplier bit per step, low WIDTH bits of the product.
// Latency WIDTH steps after load; the caller owns sequencing, so there is no backpressure.
module alu_iter_mul
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // product_o is the accumulator after the current step, so the final
    // step's result can be captured on the same edge that retires it.
    assign product_o = w_acc_nxt;
    assign last_o    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (load_i) begin
            r_acc    <= '0;
            r_mcand  <= a_i;
            r_mplier <= b_i;
            r_cnt    <= '0;
        end else if (step_i) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: simple ops complete one cycle after acceptance, MUL after WIDTH+1 cycles.
// Requests are taken only while busy_o is low; start_i during a multiply is dropped.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    alu_state_e       r_state;
    alu_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_product;
    logic             w_mul_last;
    logic             w_mul_load;
    logic             w_mul_step;
    logic             w_ld_simple;
    logic             w_ld_mul;
    logic             w_busy;
    logic             w_done;

    always_comb begin
        w_alu = '0;
        case (ctrl_i)
            OP_AND:  w_alu = src1_i & src2_i;
            OP_OR:   w_alu = src1_i | src2_i;
            OP_ADD:  w_alu = src1_i + src2_i;
            OP_SUB:  w_alu = src1_i - src2_i;
            OP_SLT:  w_alu[0] = ($signed(src1_i) < $signed(src2_i));
            default: w_alu = '0;
        endcase
    end

    alu_iter_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (w_mul_load),
        .step_i    (w_mul_step),
        .a_i       (src1_i),
        .b_i       (src2_i),
        .last_o    (w_mul_last),
        .product_o (w_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
    always_comb begin
        w_state_nxt = r_state;
        w_mul_load  = 1'b0;
        w_mul_step  = 1'b0;
        w_ld_simple = 1'b0;
        w_ld_mul    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_done      = (r_state == ST_DONE);
                w_state_nxt = ST_IDLE;
                if (start_i) begin
                    if (ctrl_i == OP_MUL) begin
                        w_state_nxt = ST_MUL;
                        w_mul_load  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_ld_simple = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                w_busy     = 1'b1;
                w_mul_step = 1'b1;
                if (w_mul_last) begin
                    w_state_nxt = ST_DONE;
                    w_ld_mul    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_ld_simple) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
        end else if (w_ld_mul) begin
            r_result <= w_product;
            r_zero   <= (w_product == '0);
        end
    end

    assign result_o = r_result;
    assign zero_o   = r_zero;
    assign busy_o   = w_busy;
    assign done_o   = w_done;

endmodule

// File: tb/tb_alu_iter.sv
// Directed and randomized bench for alu_iter against an arithmetic reference model.
module tb_alu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   ctrl;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic         done;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_res;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .ctrl_i   (ctrl),
        .src1_i   (src1),
        .src2_i   (src2),
        .result_o (result),
        .zero_o   (zero),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b0011: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return p[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] e;
        e = model(c, a, b);
        start = 1'b1;
        ctrl  = c;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
        ctrl  = 4'($urandom);
        src1  = $urandom;
        src2  = $urandom;
        if (c == 4'b0011) begin
            for (int i = 1; i <= W; i++) begin
                check({tag, "/busy"}, W'(busy), W'(1));
                check({tag, "/early_done"}, W'(done), W'(0));
                check({tag, "/held"}, result, exp_res);
                @(negedge clk);
            end
        end
        check({tag, "/done"}, W'(done), W'(1));
        check({tag, "/busy_done"}, W'(busy), W'(0));
        check({tag, "/result"}, result, e);
        check({tag, "/zero"}, W'(zero), W'(e == '0));
        exp_res = e;
    endtask

    initial begin
        logic [3:0] codes [8];
        logic [3:0] c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit seen_done;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b0100, 4'b1111};

        rst = 1'b1; start = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
        exp_res = '0;
        repeat (2) @(negedge clk);
        check("rst/result", result, '0);
        check("rst/zero", W'(zero), W'(1));
        check("rst/busy", W'(busy), W'(0));
        check("rst/done", W'(done), W'(0));
        rst = 1'b0;

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, "add_wrap_sign");
        run_op(4'b0110, 32'h1234_5678, 32'h1234_5678, "sub_zero");
        run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, "slt_neg");
        run_op(4'b0111, 32'h1, 32'hFFFF_FFFF, "slt_swap");
        run_op(4'b0011, 32'hFFFF_FFFF, 32'h3, "mul_neg1x3");
        run_op(4'b1111, 32'hABCD_0123, 32'h5555_AAAA, "bad_code");
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, "add_wrap_zero");

        // start held through a multiply with different operands
        @(negedge clk);
        check("idle/done", W'(done), W'(0));
        start = 1'b1; ctrl = 4'b0011; src1 = 32'd5; src2 = 32'd7;
        @(negedge clk);
        ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd2;
        for (int i = 1; i <= W; i++) begin
            check("hold/busy", W'(busy), W'(1));
            check("hold/early_done", W'(done), W'(0));
            @(negedge clk);
        end
        check("hold/done", W'(done), W'(1));
        check("hold/product", result, 32'd35);
        @(negedge clk);
        start = 1'b0;
        check("hold/next_done", W'(done), W'(1));
        check("hold/next_result", result, 32'd3);
        exp_res = 32'd3;

        // reset in MUL cycle 10, with a competing start
        start = 1'b1; ctrl = 4'b0011; src1 = 32'hDEAD_BEEF; src2 = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort/busy_before", W'(busy), W'(1));
        rst = 1'b1; start = 1'b1; ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd1;
        @(negedge clk);
        check("abort/busy", W'(busy), W'(0));
        check("abort/done", W'(done), W'(0));
        check("abort/result", result, '0);
        check("abort/zero", W'(zero), W'(1));
        rst = 1'b0; start = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort/no_pulse", W'(seen_done), W'(0));
        exp_res = '0;

        for (int n = 0; n < 80; n++) begin
            c = codes[$urandom_range(0, 7)];
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = '0;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 4) == 0) ? a : W'($urandom);
            run_op(c, a, b, "rand");
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                check("rand/idle_done", W'(done), W'(0));
                check("rand/idle_held", result, exp_res);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
